// File: rtl/wb_rr_arbiter_if.sv
// Shared pipelined Wishbone bundle for the round-robin arbiter:
// initiator-side request/response lanes plus the single target port.
interface wb_rr_arbiter_if #(
  parameter int ITR_CNT    = 4,
  parameter int ADR_WIDTH  = 16,
  parameter int DAT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TGA_WIDTH  = 1,
  parameter int TGC_WIDTH  = 1,
  parameter int TGRD_WIDTH = 1,
  parameter int TGWD_WIDTH = 1
);
  logic [ITR_CNT-1:0] itr_cyc_i;
  logic [ITR_CNT-1:0] itr_stb_i;
  logic [ITR_CNT-1:0] itr_we_i;
  logic [ITR_CNT-1:0] itr_lock_i;
  logic [ITR_CNT-1:0][SEL_WIDTH-1:0]  itr_sel_i;
  logic [ITR_CNT-1:0][ADR_WIDTH-1:0]  itr_adr_i;
  logic [ITR_CNT-1:0][DAT_WIDTH-1:0]  itr_dat_i;
  logic [ITR_CNT-1:0][TGA_WIDTH-1:0]  itr_tga_i;
  logic [ITR_CNT-1:0][TGC_WIDTH-1:0]  itr_tgc_i;
  logic [ITR_CNT-1:0][TGWD_WIDTH-1:0] itr_tgd_i;

  logic [ITR_CNT-1:0]    itr_ack_o;
  logic [ITR_CNT-1:0]    itr_err_o;
  logic [ITR_CNT-1:0]    itr_rty_o;
  logic [ITR_CNT-1:0]    itr_stall_o;
  logic [DAT_WIDTH-1:0]  itr_dat_o;
  logic [TGRD_WIDTH-1:0] itr_tgd_o;

  logic                  tgt_cyc_o;
  logic                  tgt_stb_o;
  logic                  tgt_we_o;
  logic                  tgt_lock_o;
  logic [SEL_WIDTH-1:0]  tgt_sel_o;
  logic [ADR_WIDTH-1:0]  tgt_adr_o;
  logic [DAT_WIDTH-1:0]  tgt_dat_o;
  logic [TGA_WIDTH-1:0]  tgt_tga_o;
  logic [TGC_WIDTH-1:0]  tgt_tgc_o;
  logic [TGWD_WIDTH-1:0] tgt_tgd_o;

  logic                  tgt_ack_i;
  logic                  tgt_err_i;
  logic                  tgt_rty_i;
  logic                  tgt_stall_i;
  logic [DAT_WIDTH-1:0]  tgt_dat_i;
  logic [TGRD_WIDTH-1:0] tgt_tgd_i;

  logic [ITR_CNT-1:0]    gnt_o;

  modport master (
    input  itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i,
    input  itr_sel_i, itr_adr_i, itr_dat_i,
    input  itr_tga_i, itr_tgc_i, itr_tgd_i,
    output itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o,
    output itr_dat_o, itr_tgd_o,
    output tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o,
    output tgt_sel_o, tgt_adr_o, tgt_dat_o,
    output tgt_tga_o, tgt_tgc_o, tgt_tgd_o,
    input  tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i,
    input  tgt_dat_i, tgt_tgd_i,
    output gnt_o
  );

  modport slave (
    output itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i,
    output itr_sel_i, itr_adr_i, itr_dat_i,
    output itr_tga_i, itr_tgc_i, itr_tgd_i,
    input  itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o,
    input  itr_dat_o, itr_tgd_o,
    input  tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o,
    input  tgt_sel_o, tgt_adr_o, tgt_dat_o,
    input  tgt_tga_o, tgt_tgc_o, tgt_tgd_o,
    output tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i,
    output tgt_dat_i, tgt_tgd_i,
    input  gnt_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone target among
// ITR_CNT initiators, with lock hold and outstanding-request tracking.
module wb_rr_arbiter #(
  parameter int ITR_CNT    = 4,
  parameter int ADR_WIDTH  = 16,
  parameter int DAT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TGA_WIDTH  = 1,
  parameter int TGC_WIDTH  = 1,
  parameter int TGRD_WIDTH = 1,
  parameter int TGWD_WIDTH = 1,
  parameter int OCNT_WIDTH = 4
) (
  input  logic clk_i,
  input  logic async_rst_i,
  wb_rr_arbiter_if.master bus
);
  localparam int IW = (ITR_CNT > 1) ? $clog2(ITR_CNT) : 1;
  localparam logic [OCNT_WIDTH-1:0] OCNT_MAX = '1;
  localparam logic [ITR_CNT-1:0] ONE = ITR_CNT'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state;
  logic [ITR_CNT-1:0]    gnt_reg, gnt_nxt;
  logic [IW-1:0]         ptr_reg, ptr_nxt;
  logic [OCNT_WIDTH-1:0] ocnt_reg, ocnt_nxt;
  logic [IW-1:0]         g_idx, base, win_idx;
  logic                  win_vld;
  logic                  g_cyc, g_lock, ocnt_full;
  logic                  req, rsp;

  logic                  mux_stb, mux_we, mux_lock;
  logic [SEL_WIDTH-1:0]  mux_sel;
  logic [ADR_WIDTH-1:0]  mux_adr;
  logic [DAT_WIDTH-1:0]  mux_dat;
  logic [TGA_WIDTH-1:0]  mux_tga;
  logic [TGC_WIDTH-1:0]  mux_tgc;
  logic [TGWD_WIDTH-1:0] mux_tgd;

  assign state     = (|gnt_reg) ? GRANT : IDLE;
  assign g_cyc     = |(gnt_reg & bus.itr_cyc_i);
  assign g_lock    = |(gnt_reg & bus.itr_lock_i);
  assign ocnt_full = (ocnt_reg == OCNT_MAX);

  always_comb begin
    g_idx = '0;
    for (int n = 0; n < ITR_CNT; n++)
      if (gnt_reg[n]) g_idx = IW'(n);
  end

  // Search starts just past the current holder, or past the last
  // released grant when idle.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    base    = (state == GRANT) ? g_idx : ptr_reg;
    for (int k = 1; k <= ITR_CNT; k++) begin
      if (!win_vld &&
          bus.itr_cyc_i[IW'((int'(base) + k) % ITR_CNT)]) begin
        win_vld = 1'b1;
        win_idx = IW'((int'(base) + k) % ITR_CNT);
      end
    end
  end

  always_comb begin
    gnt_nxt = gnt_reg;
    ptr_nxt = ptr_reg;
    unique case (state)
      IDLE: begin
        if (win_vld) gnt_nxt = ONE << win_idx;
      end
      GRANT: begin
        if (!(g_cyc || g_lock)) begin
          ptr_nxt = g_idx;
          gnt_nxt = win_vld ? (ONE << win_idx) : '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mux_stb  = 1'b0;
    mux_we   = 1'b0;
    mux_lock = 1'b0;
    mux_sel  = '0;
    mux_adr  = '0;
    mux_dat  = '0;
    mux_tga  = '0;
    mux_tgc  = '0;
    mux_tgd  = '0;
    for (int n = 0; n < ITR_CNT; n++) begin
      mux_stb  |= gnt_reg[n] & bus.itr_stb_i[n];
      mux_we   |= gnt_reg[n] & bus.itr_we_i[n];
      mux_lock |= gnt_reg[n] & bus.itr_lock_i[n];
      mux_sel  |= {SEL_WIDTH{gnt_reg[n]}} & bus.itr_sel_i[n];
      mux_adr  |= {ADR_WIDTH{gnt_reg[n]}} & bus.itr_adr_i[n];
      mux_dat  |= {DAT_WIDTH{gnt_reg[n]}} & bus.itr_dat_i[n];
      mux_tga  |= {TGA_WIDTH{gnt_reg[n]}} & bus.itr_tga_i[n];
      mux_tgc  |= {TGC_WIDTH{gnt_reg[n]}} & bus.itr_tgc_i[n];
      mux_tgd  |= {TGWD_WIDTH{gnt_reg[n]}} & bus.itr_tgd_i[n];
    end
  end

  assign bus.tgt_cyc_o  = g_cyc;
  assign bus.tgt_stb_o  = mux_stb & ~ocnt_full;
  assign bus.tgt_we_o   = mux_we;
  assign bus.tgt_lock_o = mux_lock;
  assign bus.tgt_sel_o  = mux_sel;
  assign bus.tgt_adr_o  = mux_adr;
  assign bus.tgt_dat_o  = mux_dat;
  assign bus.tgt_tga_o  = mux_tga;
  assign bus.tgt_tgc_o  = mux_tgc;
  assign bus.tgt_tgd_o  = mux_tgd;

  assign bus.itr_stall_o = ~gnt_reg |
    (gnt_reg & {ITR_CNT{bus.tgt_stall_i | ocnt_full}});
  assign bus.itr_ack_o = gnt_reg & {ITR_CNT{bus.tgt_ack_i}};
  assign bus.itr_err_o = gnt_reg & {ITR_CNT{bus.tgt_err_i}};
  assign bus.itr_rty_o = gnt_reg & {ITR_CNT{bus.tgt_rty_i}};
  assign bus.itr_dat_o = bus.tgt_dat_i;
  assign bus.itr_tgd_o = bus.tgt_tgd_i;
  assign bus.gnt_o     = gnt_reg;

  assign req = bus.tgt_cyc_o & bus.tgt_stb_o & ~bus.tgt_stall_i;
  assign rsp = bus.tgt_ack_i | bus.tgt_err_i | bus.tgt_rty_i;

  // A dropped cycle aborts whatever was still in flight.
  always_comb begin
    ocnt_nxt = ocnt_reg;
    if (!g_cyc)
      ocnt_nxt = '0;
    else if (req && !rsp)
      ocnt_nxt = ocnt_reg + 1'b1;
    else if (rsp && !req && ocnt_reg != '0)
      ocnt_nxt = ocnt_reg - 1'b1;
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      gnt_reg  <= '0;
      ptr_reg  <= IW'(ITR_CNT - 1);
      ocnt_reg <= '0;
    end else begin
      gnt_reg  <= gnt_nxt;
      ptr_reg  <= ptr_nxt;
      ocnt_reg <= ocnt_nxt;
    end
  end
endmodule
